// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared definitions for the sequential ALU.
//   op_e    : 4-bit opcode enum (mnemonics show up in waveforms)
//   state_e : controller state enum; ST_MUL exists only when the
//             iterative multiplier is built (macro ALU_SEQ_MUL_EN)
//   is_shift: true for the multi-cycle shift opcodes
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_ORR = 4'd3,
    OP_XOR = 4'd4,
    OP_RXR = 4'd5,
    OP_LSL = 4'd6,
    OP_LSR = 4'd7,
    OP_MUL = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
`ifdef ALU_SEQ_MUL_EN
    ST_MUL   = 2'd2,
`endif
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_shift(input op_e op);
    return (op == OP_LSL) || (op == OP_LSR);
  endfunction

endpackage

// File: rtl/alu_seq_core.sv
// alu_core -- combinational single-cycle operations.
//   a_i, b_i : operands (WIDTH bits)
//   op_i     : opcode; only ADD..RXR produce a value, anything else gives 0
//   y_o      : result (WIDTH bits)
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] y_o
);

  // Single-cycle result mux; carries and borrows fall off the top.
  always_comb begin
    y_o = {WIDTH{1'b0}};
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_ORR:  y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_RXR:  y_o = {{(WIDTH-1){1'b0}}, ^a_i};
      default: y_o = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq -- sequential ALU with valid/ready handshakes on both sides.
//   Clk, Reset        : clock; synchronous active-high reset
//   InputA, InputB, OP: operands and opcode, captured when InValid&&InReady
//   InValid / InReady : request handshake (InReady only in IDLE)
//   OutValid/OutReady : result handshake; result held until taken
//   Out, Zero, LT     : result, Out==0, signed InputA < signed InputB
// Shifts iterate one bit per cycle; MUL is an iterative shift-add that is
// only built when macro ALU_SEQ_MUL_EN is defined (otherwise OP=8 gives 0).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic [3:0]       OP,
  input  logic             InValid,
  output logic             InReady,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             LT
);

  localparam int               CW       = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] W_LIMIT  = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  state_e           state_q;
  logic             ready_q;
  logic             valid_q;
  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic             lt_q;
  logic [WIDTH-1:0] acc_q;      // shift value or running product
  logic [CW-1:0]    cnt_q;      // iterations left
  logic             dir_q;      // 1: shift right
  logic             lt_pend_q;  // LT of the accepted operands
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand_q;    // multiplicand, doubled each step
  logic [WIDTH-1:0] mplier_q;   // multiplier, consumed LSB first
  logic [WIDTH-1:0] acc_mul_d;
`endif

  op_e              op_in_s;
  logic [CW-1:0]    k_s;
  logic             lt_in_s;
  logic [WIDTH-1:0] core_y_s;
  logic [WIDTH-1:0] single_d;
  logic [WIDTH-1:0] acc_shift_d;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i (InputA),
    .b_i (InputB),
    .op_i(op_in_s),
    .y_o (core_y_s)
  );

  // Request decode plus the next value of each iterative datapath.
  always_comb begin
    op_in_s = op_e'(OP);
    lt_in_s = $signed(InputA) < $signed(InputB);
    // Amounts of WIDTH or more all clear the word, so clamp the count.
    if (InputB >= W_LIMIT) begin
      k_s = CNT_FULL;
    end else begin
      k_s = CW'(InputB);
    end
    // A zero-amount shift finishes at once and passes InputA through.
    if (is_shift(op_in_s)) begin
      single_d = InputA;
    end else begin
      single_d = core_y_s;
    end
    if (dir_q) begin
      acc_shift_d = acc_q >> 1;
    end else begin
      acc_shift_d = acc_q << 1;
    end
`ifdef ALU_SEQ_MUL_EN
    if (mplier_q[0]) begin
      acc_mul_d = acc_q + mcand_q;
    end else begin
      acc_mul_d = acc_q;
    end
`endif
  end

  // Controller FSM with all handshake and result registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      out_q     <= {WIDTH{1'b0}};
      zero_q    <= 1'b0;
      lt_q      <= 1'b0;
      acc_q     <= {WIDTH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      dir_q     <= 1'b0;
      lt_pend_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q   <= {WIDTH{1'b0}};
      mplier_q  <= {WIDTH{1'b0}};
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (InValid) begin
            ready_q   <= 1'b0;
            lt_pend_q <= lt_in_s;
            if (is_shift(op_in_s) && (k_s != {CW{1'b0}})) begin
              acc_q   <= InputA;
              dir_q   <= (op_in_s == OP_LSR);
              cnt_q   <= k_s;
              state_q <= ST_SHIFT;
            end
`ifdef ALU_SEQ_MUL_EN
            else if (op_in_s == OP_MUL) begin
              acc_q    <= {WIDTH{1'b0}};
              mcand_q  <= InputA;
              mplier_q <= InputB;
              cnt_q    <= CNT_FULL;
              state_q  <= ST_MUL;
            end
`endif
            else begin
              out_q   <= single_d;
              zero_q  <= (single_d == {WIDTH{1'b0}});
              lt_q    <= lt_in_s;
              valid_q <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          acc_q <= acc_shift_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            out_q   <= acc_shift_d;
            zero_q  <= (acc_shift_d == {WIDTH{1'b0}});
            lt_q    <= lt_pend_q;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        ST_MUL: begin
          acc_q    <= acc_mul_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            out_q   <= acc_mul_d;
            zero_q  <= (acc_mul_d == {WIDTH{1'b0}});
            lt_q    <= lt_pend_q;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (OutReady) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign InReady  = ready_q;
  assign OutValid = valid_q;
  assign Out      = out_q;
  assign Zero     = zero_q;
  assign LT       = lt_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] InputA, InputB;
  logic [3:0] OP;
  logic       InValid, InReady, OutValid, OutReady;
  logic [7:0] Out;
  logic       Zero, LT;

  typedef struct {
    logic [7:0] out;
    logic       zero;
    logic       lt;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 Clk = ~Clk;

  alu_seq #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .InputA(InputA), .InputB(InputB), .OP(OP),
    .InValid(InValid), .InReady(InReady), .OutValid(OutValid),
    .OutReady(OutReady), .Out(Out), .Zero(Zero), .LT(LT)
  );

  // Reference model: result, flags and edges from acceptance to OutValid
  // (the acceptance edge itself counts as edge 1).
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] op);
    exp_t e;
    int   k;
    k     = (b > 8'd8) ? 8 : int'(b);
    e.lat = 1;
    case (op)
      4'd0: e.out = a + b;
      4'd1: e.out = a - b;
      4'd2: e.out = a & b;
      4'd3: e.out = a | b;
      4'd4: e.out = a ^ b;
      4'd5: e.out = {7'd0, ^a};
      4'd6: begin e.out = (k >= 8) ? 8'd0 : (a << k); e.lat = k + 1; end
      4'd7: begin e.out = (k >= 8) ? 8'd0 : (a >> k); e.lat = k + 1; end
`ifdef ALU_SEQ_MUL_EN
      4'd8: begin e.out = 8'((16'(a) * 16'(b)) & 16'hFF); e.lat = 9; end
`endif
      default: e.out = 8'd0;
    endcase
    e.zero = (e.out == 8'd0);
    e.lt   = ($signed(a) < $signed(b));
    return e;
  endfunction

  // Present a request, push its expectation, hold InValid until accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic rdy;
    sb_q.push_back(model(a, b, op));
    @(negedge Clk);
    InputA = a; InputB = b; OP = op; InValid = 1'b1;
    for (int g = 0; g < 50; g++) begin
      rdy = InReady;
      @(posedge Clk);
      if (rdy === 1'b1) break;
      @(negedge Clk);
    end
    #1;
    InValid = 1'b0;
  endtask

  // Count edges until OutValid; -1 when the bound expires.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (OutValid !== 1'b1 && lat < 100) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    if (OutValid !== 1'b1) lat = -1;
  endtask

  task automatic release_result();
    @(negedge Clk);
    OutReady = 1'b1;
    @(posedge Clk);
    #1;
    OutReady = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp += 5;
    if (OutValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", OutValid); end
    if (InReady !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", InReady); end
    if (Out !== 8'h00) begin n_bad++; $display("FAIL reset_out: got %h expected 00", Out); end
    if (Zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero: got %b expected 0", Zero); end
    if (LT !== 1'b0) begin n_bad++; $display("FAIL reset_lt: got %b expected 0", LT); end
  endtask

  task automatic test_single();
    logic [7:0] ta[9] = '{8'hF0, 8'h05, 8'h80, 8'hCA, 8'h12, 8'h5A, 8'h07, 8'h06, 8'h3C};
    logic [7:0] tb[9] = '{8'h20, 8'h05, 8'h01, 8'h0F, 8'h40, 8'hFF, 8'h00, 8'h00, 8'h10};
    logic [3:0] to[9] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd15};
    exp_t e;
    int   lat;
    for (int i = 0; i < 9; i++) begin
      send(ta[i], tb[i], to[i]);
      wait_valid(lat);
      e = sb_q.pop_front();
      n_cmp += 4;
      if (Out !== e.out) begin n_bad++; $display("FAIL single_out[%0d]: got %h expected %h", i, Out, e.out); end
      if (Zero !== e.zero) begin n_bad++; $display("FAIL single_zero[%0d]: got %b expected %b", i, Zero, e.zero); end
      if (LT !== e.lt) begin n_bad++; $display("FAIL single_lt[%0d]: got %b expected %b", i, LT, e.lt); end
      if (lat != e.lat) begin n_bad++; $display("FAIL single_lat[%0d]: got %0d expected %0d", i, lat, e.lat); end
      release_result();
      n_cmp++;
      if (InReady !== 1'b1 || OutValid !== 1'b0) begin
        n_bad++; $display("FAIL single_drop[%0d]: got rdy=%b vld=%b expected rdy=1 vld=0", i, InReady, OutValid);
      end
    end
  endtask

  task automatic test_shift();
    logic [7:0] ta[6] = '{8'h01, 8'hFF, 8'h5D, 8'h80, 8'hB3, 8'h01};
    logic [7:0] tb[6] = '{8'd3, 8'd9, 8'd0, 8'd7, 8'd1, 8'd8};
    logic [3:0] to[6] = '{4'd6, 4'd7, 4'd6, 4'd7, 4'd7, 4'd6};
    exp_t e;
    int   lat;
    for (int i = 0; i < 6; i++) begin
      send(ta[i], tb[i], to[i]);
      wait_valid(lat);
      e = sb_q.pop_front();
      n_cmp += 3;
      if (Out !== e.out) begin n_bad++; $display("FAIL shift_out[%0d]: got %h expected %h", i, Out, e.out); end
      if (Zero !== e.zero) begin n_bad++; $display("FAIL shift_zero[%0d]: got %b expected %b", i, Zero, e.zero); end
      if (lat != e.lat) begin n_bad++; $display("FAIL shift_lat[%0d]: got %0d expected %0d", i, lat, e.lat); end
      release_result();
    end
  endtask

  task automatic test_mul();
    exp_t e;
    int   lat;
    send(8'h0F, 8'h11, 4'd8);
    wait_valid(lat);
    e = sb_q.pop_front();
    n_cmp += 3;
    if (Out !== e.out) begin n_bad++; $display("FAIL mul_out: got %h expected %h", Out, e.out); end
    if (LT !== e.lt) begin n_bad++; $display("FAIL mul_lt: got %b expected %b", LT, e.lt); end
    if (lat != e.lat) begin n_bad++; $display("FAIL mul_lat: got %0d expected %0d", lat, e.lat); end
    release_result();
  endtask

  task automatic test_hold();
    exp_t e;
    int   lat;
    send(8'hF0, 8'h20, 4'd0);
    wait_valid(lat);
    e = sb_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      InputA = 8'h01; InputB = 8'h01; OP = 4'd1; InValid = 1'b1;
      @(posedge Clk);
      #1;
      n_cmp += 3;
      if (OutValid !== 1'b1 || Out !== e.out) begin
        n_bad++; $display("FAIL hold_out[%0d]: got vld=%b out=%h expected vld=1 out=%h", c, OutValid, Out, e.out);
      end
      if (Zero !== e.zero || LT !== e.lt) begin
        n_bad++; $display("FAIL hold_flags[%0d]: got z=%b lt=%b expected z=%b lt=%b", c, Zero, LT, e.zero, e.lt);
      end
      if (InReady !== 1'b0) begin n_bad++; $display("FAIL hold_ready[%0d]: got %b expected 0", c, InReady); end
    end
    @(negedge Clk);
    InValid = 1'b0;
    release_result();
    n_cmp++;
    if (InReady !== 1'b1 || OutValid !== 1'b0) begin
      n_bad++; $display("FAIL hold_release: got rdy=%b vld=%b expected rdy=1 vld=0", InReady, OutValid);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk);
      #1;
      n_cmp++;
      if (OutValid !== 1'b0) begin n_bad++; $display("FAIL hold_ghost[%0d]: got vld=%b expected 0", c, OutValid); end
    end
  endtask

  task automatic test_reset_mid();
    send(8'h80, 8'd7, 4'd7);
    void'(sb_q.pop_front());
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    InValid = 1'b1;
    OutReady = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    n_cmp += 3;
    if (OutValid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b expected 0", OutValid); end
    if (InReady !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b expected 1", InReady); end
    if (Out !== 8'h00) begin n_bad++; $display("FAIL rstmid_out: got %h expected 00", Out); end
    for (int c = 0; c < 12; c++) begin
      @(posedge Clk);
      #1;
      n_cmp++;
      if (OutValid !== 1'b0) begin n_bad++; $display("FAIL rstmid_stale[%0d]: got vld=%b expected 0", c, OutValid); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    logic [7:0] a, b;
    logic [3:0] op;
    @(negedge Clk);
    OutReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a  = 8'($urandom);
      b  = (i % 2 == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      op = 4'($urandom_range(0, 15));
      send(a, b, op);
      wait_valid(lat);
      e = sb_q.pop_front();
      n_cmp += 4;
      if (Out !== e.out) begin n_bad++; $display("FAIL b2b_out[%0d] op=%0d: got %h expected %h", i, op, Out, e.out); end
      if (Zero !== e.zero) begin n_bad++; $display("FAIL b2b_zero[%0d]: got %b expected %b", i, Zero, e.zero); end
      if (LT !== e.lt) begin n_bad++; $display("FAIL b2b_lt[%0d]: got %b expected %b", i, LT, e.lt); end
      if (lat != e.lat) begin n_bad++; $display("FAIL b2b_lat[%0d] op=%0d: got %0d expected %0d", i, op, lat, e.lat); end
    end
    @(posedge Clk);
    #1;
    OutReady = 1'b0;
    n_cmp++;
    if (sb_q.size() != 0) begin n_bad++; $display("FAIL b2b_queue: got %0d left expected 0", sb_q.size()); end
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    InputA = 8'h00; InputB = 8'h00; OP = 4'd0;
    repeat (2) @(posedge Clk);
    #1;
    test_reset();
    Reset = 1'b0;
    test_single();
    test_shift();
    test_mul();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
